// File: rtl/buffer_fifo.sv
// Synchronous FIFO of WIDTH-bit words, DEPTH entries, with registered flags and read data.
// Define BUFFER_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef BUFFER_FIFO_ERR_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;
            count    <= count_nxt;
            // Flags follow the next count so they are valid in the same cycle as count.
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == CW'(DEPTH));
        end
    end

`ifdef BUFFER_FIFO_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)
                overflow <= 1'b1;
            if (rd_en & empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// Directed bench for buffer_fifo: DEPTH=4 instance for boundary cases, DEPTH=3 for wrap-around.
// Optional error outputs are checked when BUFFER_FIFO_ERR_EN is defined.
`timescale 1ns/1ps
module tb_buffer_fifo;

    logic       clk = 1'b0;
    logic       reset;

    logic       wr_en_a, rd_en_a, full_a, empty_a, rd_valid_a;
    logic [7:0] wr_data_a, rd_data_a;
    logic [2:0] count_a;

    logic       wr_en_b, rd_en_b, full_b, empty_b, rd_valid_b;
    logic [7:0] wr_data_b, rd_data_b;
    logic [1:0] count_b;

`ifdef BUFFER_FIFO_ERR_EN
    logic       overflow_a, underflow_a, overflow_b, underflow_b;
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    buffer_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
        .rd_en(rd_en_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .empty(empty_a), .count(count_a)
`ifdef BUFFER_FIFO_ERR_EN
        , .overflow(overflow_a), .underflow(underflow_a)
`endif
    );

    buffer_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
        .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .empty(empty_b), .count(count_b)
`ifdef BUFFER_FIFO_ERR_EN
        , .overflow(overflow_b), .underflow(underflow_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic w, input logic [7:0] d, input logic r);
        wr_en_a   = w;
        wr_data_a = d;
        rd_en_a   = r;
        tick();
        wr_en_a = 1'b0;
        rd_en_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en_a = 0; rd_en_a = 0; wr_data_a = 0;
        wr_en_b = 0; rd_en_b = 0; wr_data_b = 0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(count_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_rd_valid", 32'(rd_valid_a), 0);
        chk("rst_rd_data", 32'(rd_data_a), 0);

        // Wrap-around on DEPTH=3: prime one word, then stream with concurrent read/write
        wr_en_b = 1; wr_data_b = 8'h01;
        tick();
        chk("wrap_prime_count", 32'(count_b), 1);
        rd_en_b = 1;
        for (int i = 2; i <= 10; i++) begin
            wr_data_b = 8'(i);
            tick();
            chk($sformatf("wrap_data_%0d", i - 1), 32'(rd_data_b), 32'(i - 1));
            chk($sformatf("wrap_count_%0d", i - 1), 32'(count_b), 1);
            chk($sformatf("wrap_valid_%0d", i - 1), 32'(rd_valid_b), 1);
        end
        wr_en_b = 0;
        tick();
        rd_en_b = 0;
        chk("wrap_data_10", 32'(rd_data_b), 32'h0A);
        chk("wrap_final_count", 32'(count_b), 0);
        chk("wrap_final_empty", 32'(empty_b), 1);

        // Asynchronous reset mid-run with two entries stored
        op_a(1, 8'hAA, 0);
        chk("lat_empty_deassert", 32'(empty_a), 0);
        op_a(1, 8'hBB, 0);
        op_a(1, 8'hCC, 0);
        op_a(0, 8'h00, 1);
        chk("pre_rst_rd_data", 32'(rd_data_a), 32'hAA);
        chk("pre_rst_count", 32'(count_a), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count_a), 0);
        chk("arst_empty", 32'(empty_a), 1);
        chk("arst_full", 32'(full_a), 0);
        chk("arst_rd_data", 32'(rd_data_a), 0);
        chk("arst_rd_valid", 32'(rd_valid_a), 0);
        #2 reset = 1'b0;

        // Fill to full
        op_a(1, 8'h11, 0);
        op_a(1, 8'h22, 0);
        op_a(1, 8'h33, 0);
        chk("fill3_full", 32'(full_a), 0);
        op_a(1, 8'h44, 0);
        chk("fill_full", 32'(full_a), 1);
        chk("fill_count", 32'(count_a), 4);

        // Write while full is dropped
        op_a(1, 8'h55, 0);
        chk("ovf_count", 32'(count_a), 4);
        chk("ovf_full", 32'(full_a), 1);
`ifdef BUFFER_FIFO_ERR_EN
        chk("ovf_flag", 32'(overflow_a), 1);
`endif

        // Drain
        op_a(0, 8'h00, 1);
        chk("drain_d0", 32'(rd_data_a), 32'h11);
        chk("drain_v0", 32'(rd_valid_a), 1);
        op_a(0, 8'h00, 1);
        chk("drain_d1", 32'(rd_data_a), 32'h22);
        chk("drain_v1", 32'(rd_valid_a), 1);
        op_a(0, 8'h00, 1);
        chk("drain_d2", 32'(rd_data_a), 32'h33);
        op_a(0, 8'h00, 1);
        chk("drain_d3", 32'(rd_data_a), 32'h44);
        chk("drain_v3", 32'(rd_valid_a), 1);
        chk("drain_empty", 32'(empty_a), 1);
        chk("drain_count", 32'(count_a), 0);
        op_a(0, 8'h00, 0);
        chk("idle_valid", 32'(rd_valid_a), 0);
        chk("idle_hold", 32'(rd_data_a), 32'h44);

        // Read while empty is ignored
        op_a(0, 8'h00, 1);
        chk("udf_valid", 32'(rd_valid_a), 0);
        chk("udf_hold", 32'(rd_data_a), 32'h44);
        chk("udf_count", 32'(count_a), 0);
`ifdef BUFFER_FIFO_ERR_EN
        chk("udf_flag", 32'(underflow_a), 1);
        op_a(0, 8'h00, 0);
        chk("udf_sticky", 32'(underflow_a), 1);
        chk("ovf_sticky", 32'(overflow_a), 1);
`endif

        // Full with simultaneous write and read: read wins
        op_a(1, 8'h11, 0);
        op_a(1, 8'h22, 0);
        op_a(1, 8'h33, 0);
        op_a(1, 8'h44, 0);
        op_a(1, 8'h66, 1);
        chk("fullrw_data", 32'(rd_data_a), 32'h11);
        chk("fullrw_valid", 32'(rd_valid_a), 1);
        chk("fullrw_count", 32'(count_a), 3);
        chk("fullrw_full", 32'(full_a), 0);
        op_a(0, 8'h00, 1);
        chk("fullrw_d1", 32'(rd_data_a), 32'h22);
        op_a(0, 8'h00, 1);
        chk("fullrw_d2", 32'(rd_data_a), 32'h33);
        op_a(0, 8'h00, 1);
        chk("fullrw_d3", 32'(rd_data_a), 32'h44);
        chk("fullrw_empty", 32'(empty_a), 1);

        // Empty with simultaneous write and read: write wins
        op_a(1, 8'h77, 1);
        chk("emptyrw_valid", 32'(rd_valid_a), 0);
        chk("emptyrw_count", 32'(count_a), 1);
        chk("emptyrw_empty", 32'(empty_a), 0);
        chk("emptyrw_hold", 32'(rd_data_a), 32'h44);
        op_a(0, 8'h00, 1);
        chk("emptyrw_data", 32'(rd_data_a), 32'h77);
        chk("emptyrw_valid2", 32'(rd_valid_a), 1);
        chk("emptyrw_count2", 32'(count_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/buffer_fifo.md
Name: buffer_fifo

Overview:
- Parametrised successor of the single-bit combinational buffer: a synchronous, clocked storage buffer of WIDTH-bit words, DEPTH entries deep, first-in first-out.
- Decouples a producer and a consumer that run on the same clock with independent write and read enables.
- Used wherever a value must be held across cycles rather than passed straight through, e.g. between test stimulus blocks and the combinational gate modules.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, need not be a power of two)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_data  input  WIDTH  word to store
full  output  1  no free entry; writes are dropped
rd_en  input  1  read request
rd_data  output  WIDTH  last word popped; registered
rd_valid  output  1  one-cycle pulse: rd_data was updated by the previous edge
empty  output  1  no stored entry; reads are ignored
count  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset, asserted at any time including mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0.
  - Storage contents are don't-care and are never observable after reset.
- Accept rules, evaluated on the state at the start of the cycle:
  - write accepted = wr_en & ~full.
  - read accepted = rd_en & ~empty.
- Write: on the accepting edge, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read: on the accepting edge, rd_data <= mem[rd_ptr], rd_ptr advances, and rd_valid=1 for the following cycle.
  - With no accepted read, rd_valid=0 and rd_data holds its value.
- Pointer wrap: each pointer increments and returns from DEPTH-1 to 0. No power-of-two arithmetic is allowed.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Flags are registered and derived from the next count:
  - empty = (count==0).
  - full = (count==DEPTH).
- Latency:
  - Write at edge N → empty deasserts after edge N.
  - The earliest read request is in cycle N+1, with data on rd_data after edge N+1.
  - Minimum write-to-data latency is 2 edges.
- Simultaneous events:
  - Full plus wr_en and rd_en: the read is accepted, the write is dropped, and count becomes DEPTH-1.
  - Empty plus wr_en and rd_en: the write is accepted, the read is ignored, count becomes 1, and rd_valid=0.
  - Neither empty nor full, both enables high: both are accepted, count is unchanged, and ordering is preserved.
- Illegal requests: wr_en while full and rd_en while empty are silently ignored. State is unchanged apart from the optional error flags.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BUFFER_FIFO_ERR_EN.
- Defined: adds output ports overflow (1 bit) and underflow (1 bit).
  - overflow is set on the edge where wr_en & full.
  - underflow is set on the edge where rd_en & empty.
  - Both are sticky until reset and reset to 0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-run at time 3 with 2 entries stored → count=0, empty=1, full=0, rd_data=0, rd_valid=0 immediately, without waiting for a clock edge.
- Fill and drain (WIDTH=8, DEPTH=4):
  - Write 8'h11, 8'h22, 8'h33, 8'h44 → full=1, count=4.
  - Read 4 times → rd_data=11, 22, 33, 44, each with rd_valid pulsing, then empty=1.
- Overflow drop: with the buffer full of 11..44, wr_en with 8'h55 → count stays 4 and later reads return 11..44 (55 absent). With BUFFER_FIFO_ERR_EN defined, overflow=1.
- Simultaneous at the boundaries:
  - Full, wr 8'h66 + rd → rd_data=11, count=3, 66 not stored.
  - Empty, wr 8'h77 + rd → rd_valid=0, count=1, next read returns 77.
- Wrap-around (DEPTH=3):
  - Stream 10 words 8'h01..8'h0A with concurrent write and read after priming 1 word.
  - Outputs are 01..0A in order; count stays 1 throughout; both pointers wrap 3 times.
- Underflow: rd_en while empty → rd_valid=0 and rd_data unchanged. With BUFFER_FIFO_ERR_EN, underflow=1 and it stays 1 until reset.
